mux8_arbiter: RTL and testbench



---
 rtl/mux8_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mux8_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_arbiter
//   Round-robin arbiter and sequencer for a shared 8:1 multiplexed resource.
//   It grants one requester at a time and drives the mux select bits.
//   It re-arbitrates on the same edge that an owner releases, so there is no
//   dead cycle between owners. All outputs are registered.
//
//   Optional feature (compile-time macro MUX8_ARB_TIMEOUT_EN):
//     When the macro is defined, a hold counter limits each tenure to MAX_HOLD
//     cycles. On a forced release the arbiter pulses `timeout` for one cycle,
//     together with the next grant or with the return to IDLE.
//     When the macro is undefined, no counter is built and `timeout` is 0.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous active-high reset
//   req      in   8  request vector, bit i = requester i wants the mux
//   grant    out  8  one-hot grant, zero when idle (registered)
//   valid    out  1  high while a grant is active (OR of grant)
//   sel0     out  1  owner index bit 0
//   sel1     out  1  owner index bit 1
//   sel2     out  1  owner index bit 2 (MSB)
//   timeout  out  1  one-cycle pulse on a forced release
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..255).
//             Only used with MUX8_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module mux8_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       valid,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] ptr;
  logic [2:0] ptr_next;
  logic [2:0] owner;
  logic [2:0] owner_next;
  logic [7:0] grant_next;
  logic       valid_next;
  logic [7:0] cand;
  logic [3:0] pick;
  logic       forced;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux8_arbiter: MAX_HOLD must be in 1..255");
  end

  // Round-robin search: returns {found, index}.
  // The first set bit of r is searched at p, p+1, ..., p+7 (mod 8).
  function automatic logic [3:0] find_first(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'h0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!res[3] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Next-state, pointer and grant selection.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    grant_next = grant;
    valid_next = valid;
    cand       = 8'h00;
    pick       = 4'h0;
    case (state)
      IDLE: begin
        cand = req;
        pick = find_first(cand, ptr);
        if (pick[3]) begin
          state_next = BUSY;
          owner_next = pick[2:0];
          grant_next = 8'h01 << pick[2:0];
          valid_next = 1'b1;
        end else begin
          // sel (owner) keeps its value so the mux output stays stable
          grant_next = 8'h00;
          valid_next = 1'b0;
        end
      end
      BUSY: begin
        if (!req[owner] || forced) begin
          // Release (voluntary or forced): the search starts after the owner.
          // The owner is masked out so a forced release cannot re-grant it.
          ptr_next = owner + 3'd1;
          cand     = req & ~(8'h01 << owner);
          pick     = find_first(cand, owner + 3'd1);
          if (pick[3]) begin
            owner_next = pick[2:0];
            grant_next = 8'h01 << pick[2:0];
            valid_next = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = 8'h00;
            valid_next = 1'b0;
          end
        end else begin
          grant_next = grant;
          valid_next = valid;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'h00;
        valid_next = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      owner <= 3'd0;
      grant <= 8'h00;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      grant <= grant_next;
      valid <= valid_next;
    end
  end

  assign sel0 = owner[0];
  assign sel1 = owner[1];
  assign sel2 = owner[2];

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  // At the limit the owner has held MAX_HOLD cycles, so the next edge forces a release.
  assign forced = (state == BUSY) && req[owner] && (hold_cnt == HOLD_LIMIT);

  // Hold counter: cleared on every new grant, counts cycles while the same owner holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 8'd0;
    end else if (pick[3]) begin
      hold_cnt <= 8'd0;
    end else if (state_next == BUSY) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  // Timeout pulse, registered with the grant that follows the forced release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
    end
  end

  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8_arbiter
//   Self-checking bench for mux8_arbiter. Each stimulus cycle pushes the
//   expected {grant, valid, sel, timeout} to a scoreboard queue. The scenario
//   task pops the entry and compares it after the clock edge.
//   MAX_HOLD is set to 4. The timeout scenario checks the forced-release
//   sequence when MUX8_ARB_TIMEOUT_EN is defined. Otherwise it checks that
//   the owner holds the grant indefinitely.
// -----------------------------------------------------------------------------
module tb_mux8_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic       valid;
  logic       sel0;
  logic       sel1;
  logic       sel2;
  logic       timeout;

  typedef struct {
    logic [7:0] grant;
    logic       valid;
    logic [2:0] sel;
    logic       timeout;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [2:0] last_sel;
  int         vectors;
  int         miscompares;

  mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .valid   (valid),
    .sel0    (sel0),
    .sel1    (sel1),
    .sel2    (sel2),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive req for one cycle and queue the outputs expected after the next edge.
  // While idle, sel keeps the last owner index.
  task automatic apply(input logic [7:0] r, input logic [7:0] eg, input logic et);
    exp_t x;
    @(negedge clk);
    req = r;
    for (int i = 0; i < 8; i++) begin
      if (eg[i]) last_sel = 3'(i);
    end
    x.grant   = eg;
    x.valid   = (eg != 8'h00);
    x.sel     = last_sel;
    x.timeout = et;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 8'h00;
    @(negedge clk);
    reset    = 1'b0;
    last_sel = 3'd0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = 8'h00;
    last_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (grant !== 8'h00 || valid !== 1'b0 || {sel2, sel1, sel0} !== 3'b000 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got grant=%h valid=%b sel=%b to=%b want 00/0/000/0",
               grant, valid, {sel2, sel1, sel0}, timeout);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      apply(8'h00, 8'h00, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel || timeout !== e.timeout) begin
        miscompares++;
        $display("FAIL idle_after_reset[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 grant, valid, {sel2, sel1, sel0}, timeout, e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  task automatic test_handoff();
    logic [7:0] r_tab [3];
    logic [7:0] g_tab [3];
    r_tab = '{8'h24, 8'h20, 8'h00};
    g_tab = '{8'h04, 8'h20, 8'h00};   // last step: idle with sel held at 101
    for (int c = 0; c < 3; c++) begin
      apply(r_tab[c], g_tab[c], 1'b0);
      e = sb.pop_front();
      vectors++;
      if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel || timeout !== e.timeout) begin
        miscompares++;
        $display("FAIL handoff[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 grant, valid, {sel2, sel1, sel0}, timeout, e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] r;
    logic [7:0] g;
    pulse_reset();
    apply(8'hFF, 8'h01, 1'b0);
    e = sb.pop_front();
    vectors++;
    if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel) begin
      miscompares++;
      $display("FAIL rotation_first: got %h/%b/%b want %h/%b/%b",
               grant, valid, {sel2, sel1, sel0}, e.grant, e.valid, e.sel);
    end
    // Each owner drops its request for one cycle; the next index must win.
    for (int i = 0; i < 8; i++) begin
      r = 8'hFF;
      r[i] = 1'b0;
      g = 8'h00;
      g[(i + 1) % 8] = 1'b1;
      apply(r, g, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel || timeout !== e.timeout) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 grant, valid, {sel2, sel1, sel0}, timeout, e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    pulse_reset();
    apply(8'h08, 8'h08, 1'b0);
    apply(8'h08, 8'h08, 1'b0);
    for (int c = 0; c < 2; c++) begin
      e = sb.pop_front();
      vectors++;
      if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel) begin
        miscompares++;
        $display("FAIL busy3[%0d]: got %h/%b/%b want %h/%b/%b", c,
                 grant, valid, {sel2, sel1, sel0}, e.grant, e.valid, e.sel);
      end
    end
    // Assert reset between clock edges; outputs must clear immediately.
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (grant !== 8'h00 || valid !== 1'b0 || {sel2, sel1, sel0} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: got grant=%h valid=%b sel=%b want 00/0/000",
               grant, valid, {sel2, sel1, sel0});
    end
    @(negedge clk);
    reset    = 1'b0;
    last_sel = 3'd0;
    apply(8'h88, 8'h08, 1'b0);
    e = sb.pop_front();
    vectors++;
    if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel) begin
      miscompares++;
      $display("FAIL ptr_after_reset: got %h/%b/%b want %h/%b/%b",
               grant, valid, {sel2, sel1, sel0}, e.grant, e.valid, e.sel);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] r_tab [3];
    logic [7:0] g_tab [3];
    // Owner 3 leaves (ptr=4), then 7 wins, then 7 leaves with only 0 requesting.
    r_tab = '{8'h00, 8'h80, 8'h01};
    g_tab = '{8'h00, 8'h80, 8'h01};
    for (int c = 0; c < 3; c++) begin
      apply(r_tab[c], g_tab[c], 1'b0);
      e = sb.pop_front();
      vectors++;
      if (grant !== e.grant || valid !== e.valid || {sel2, sel1, sel0} !== e.sel || timeout !== e.timeout) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 grant, valid, {sel2, sel1, sel0}, timeout, e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    pulse_reset();
`ifdef MUX8_ARB_TIMEOUT_EN
    // Owner 0 for 4 cycles, forced to 1 (pulse), 1 for 4 cycles, forced back to 0.
    for (int c = 0; c < 4; c++) apply(8'h03, 8'h01, 1'b0);
    apply(8'h03, 8'h02, 1'b1);
    for (int c = 0; c < 3; c++) apply(8'h03, 8'h02, 1'b0);
    apply(8'h03, 8'h01, 1'b1);
    apply(8'h03, 8'h01, 1'b0);
    n = 10;
`else
    for (int c = 0; c < 110; c++) apply(8'h03, 8'h01, 1'b0);
    n = 110;
`endif
    // Entries were queued in order; compare against a captured log of outputs.
    for (int c = 0; c < n; c++) begin
      e = sb.pop_front();
      vectors++;
      if (hist_grant[c] !== e.grant || hist_valid[c] !== e.valid ||
          hist_sel[c] !== e.sel || hist_to[c] !== e.timeout) begin
        miscompares++;
        $display("FAIL timeout_seq[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 hist_grant[c], hist_valid[c], hist_sel[c], hist_to[c],
                 e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  // Output log for the long timeout run, one entry per cycle after the edge.
  logic [7:0] hist_grant [128];
  logic       hist_valid [128];
  logic [2:0] hist_sel   [128];
  logic       hist_to    [128];
  int         hist_idx;
  logic       logging;

  // Record the outputs 1 time unit after each edge while logging is active.
  always @(posedge clk) begin
    if (logging) begin
      #1;
      if (hist_idx < 128) begin
        hist_grant[hist_idx] = grant;
        hist_valid[hist_idx] = valid;
        hist_sel[hist_idx]   = {sel2, sel1, sel0};
        hist_to[hist_idx]    = timeout;
      end
      hist_idx = hist_idx + 1;
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    hist_idx    = 0;
    logging     = 1'b0;
    test_reset();
    test_handoff();
    test_rotation();
    test_reset_mid_busy();
    test_wrap();
    // Logging starts at the negedge before the first timeout-scenario stimulus edge.
    pulse_reset();
    hist_idx = 0;
    logging  = 1'b1;
    test_timeout_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Runs the timeout scenario with the log aligned to its first stimulus edge.
  task automatic test_timeout_run();
    test_timeout_body();
  endtask

  task automatic test_timeout_body();
    int n;
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) push_cycle(8'h03, 8'h01, 1'b0);
    push_cycle(8'h03, 8'h02, 1'b1);
    for (int c = 0; c < 3; c++) push_cycle(8'h03, 8'h02, 1'b0);
    push_cycle(8'h03, 8'h01, 1'b1);
    push_cycle(8'h03, 8'h01, 1'b0);
    n = 10;
`else
    for (int c = 0; c < 110; c++) push_cycle(8'h03, 8'h01, 1'b0);
    n = 110;
`endif
    logging = 1'b0;
    for (int c = 0; c < n; c++) begin
      e = sb.pop_front();
      vectors++;
      if (hist_grant[c] !== e.grant || hist_valid[c] !== e.valid ||
          hist_sel[c] !== e.sel || hist_to[c] !== e.timeout) begin
        miscompares++;
        $display("FAIL timeout_seq[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 hist_grant[c], hist_valid[c], hist_sel[c], hist_to[c],
                 e.grant, e.valid, e.sel, e.timeout);
      end
    end
  endtask

  // Same as apply, but it leaves the comparison to the recorded log.
  task automatic push_cycle(input logic [7:0] r, input logic [7:0] eg, input logic et);
    exp_t x;
    req = r;
    for (int i = 0; i < 8; i++) begin
      if (eg[i]) last_sel = 3'(i);
    end
    x.grant   = eg;
    x.valid   = (eg != 8'h00);
    x.sel     = last_sel;
    x.timeout = et;
    sb.push_back(x);
    @(negedge clk);
  endtask

endmodule
